// File: rtl/stage_fifo_nd_if.sv
`default_nettype none
// ============================================================================
//  Module   : stage_fifo_nd_if
//  Purpose  : Dual-issue write/read handshake bundle for stage_fifo_nd.
//             The master modport is the surrounding pipeline (producer and
//             consumer). The slave modport is the FIFO itself.
//  Signals  : wr_valid[1:0]  producer write request (00 / 01 / 11)
//             wr_data0/1     first / second sequential write data
//             wr_rdy[1:0]    FIFO write room (00 / 01 / 11)
//             rd_rdy[1:0]    consumer read request (00 / 01 / 11)
//             rd_valid[1:0]  FIFO read data available (00 / 01 / 11)
//             rd_data0/1     oldest / second-oldest entry
//  Revision : 1.0  initial release
// ============================================================================
interface stage_fifo_nd_if #(
  parameter int Width = 32
);
  logic [1:0]       wr_valid;
  logic [Width-1:0] wr_data0;
  logic [Width-1:0] wr_data1;
  logic [1:0]       wr_rdy;
  logic [1:0]       rd_rdy;
  logic [1:0]       rd_valid;
  logic [Width-1:0] rd_data0;
  logic [Width-1:0] rd_data1;

  modport master (
    output wr_valid, wr_data0, wr_data1, rd_rdy,
    input  wr_rdy, rd_valid, rd_data0, rd_data1
  );

  modport slave (
    input  wr_valid, wr_data0, wr_data1, rd_rdy,
    output wr_rdy, rd_valid, rd_data0, rd_data1
  );
endinterface
`default_nettype wire

// File: rtl/stage_fifo_nd.sv
`default_nettype none
// ============================================================================
//  Module   : stage_fifo_nd
//  Purpose  : Parametrised dual-issue pipeline FIFO. Up to two writes and two
//             reads per cycle, no fall-through, synchronous flush, registered
//             occupancy and almost-full outputs.
//  Ports    : clk_i          clock
//             rst_ni         asynchronous active-low reset
//             flush_i        synchronous flush (beats all handshakes)
//             bus            stage_fifo_nd_if.slave handshake bundle
//             level_o        registered occupancy
//             almost_full_o  registered level_o >= AFullLevel
//  Revision : 1.0  initial release
// ============================================================================
module stage_fifo_nd #(
  parameter int Width      = 32,
  parameter int Depth      = 4,
  parameter int AFullLevel = Depth - 1,
  parameter int PassRead   = 1
) (
  input  wire logic                       clk_i,
  input  wire logic                       rst_ni,
  input  wire logic                       flush_i,
  stage_fifo_nd_if.slave                  bus,
  output logic [$clog2(Depth+1)-1:0]      level_o,
  output logic                            almost_full_o
);

  localparam int c_lvl_w = $clog2(Depth + 1);
  localparam int c_ptr_w = $clog2(Depth);
  localparam logic [c_lvl_w:0] c_depth = (c_lvl_w + 1)'(Depth);
  localparam logic [c_lvl_w:0] c_afull = (c_lvl_w + 1)'(AFullLevel);

  typedef logic [c_ptr_w-1:0] ptr_t;

  logic [Width-1:0]   mem_q [Depth];
  logic [Width-1:0]   mem_d [Depth];
  ptr_t               rd_ptr_q, rd_ptr_d;
  ptr_t               wr_ptr_q, wr_ptr_d;
  logic [c_lvl_w-1:0] level_q, level_d;
  logic               afull_q, afull_d;

  logic [1:0]         wr_req, rd_req;
  logic [1:0]         rd_valid, wr_rdy;
  logic [1:0]         rd_acc, wr_acc;
  logic [1:0]         n_rd, n_wr;
  logic [c_lvl_w:0]   free;

  // Advance a pointer by 0..2 with explicit wrap, so any Depth works.
  function automatic ptr_t ptr_add(input ptr_t p, input logic [1:0] n);
    logic [c_ptr_w:0] s;
    s = (c_ptr_w + 1)'(p) + (c_ptr_w + 1)'(n);
    if (s >= (c_ptr_w + 1)'(Depth)) begin
      s = s - (c_ptr_w + 1)'(Depth);
    end
    return s[c_ptr_w-1:0];
  endfunction

  always_comb begin
    // The illegal request code 10 collapses to 00; 01 and 11 pass unchanged.
    wr_req   = {bus.wr_valid[1] & bus.wr_valid[0], bus.wr_valid[0]};
    rd_req   = {bus.rd_rdy[1] & bus.rd_rdy[0], bus.rd_rdy[0]};

    rd_valid = {level_q >= c_lvl_w'(2), level_q != '0};
    rd_acc   = rd_req & rd_valid;
    n_rd     = {1'b0, rd_acc[0]} + {1'b0, rd_acc[1]};

    // With PassRead=0 the read term drops out, leaving wr_rdy a pure
    // function of the registered level.
    free     = c_depth - (c_lvl_w + 1)'(level_q)
             + ((PassRead != 0) ? (c_lvl_w + 1)'(n_rd) : '0);
    wr_rdy   = {free >= (c_lvl_w + 1)'(2), free != '0};
    wr_acc   = wr_req & wr_rdy;
    n_wr     = {1'b0, wr_acc[0]} + {1'b0, wr_acc[1]};

    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;

    if (flush_i) begin
      // Storage keeps its contents; only the bookkeeping is cleared.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      // A write into the slot being read at full is safe: the read side
      // sees the registered (old) contents this cycle.
      if (wr_acc[0]) mem_d[wr_ptr_q] = bus.wr_data0;
      if (wr_acc[1]) mem_d[ptr_add(wr_ptr_q, 2'd1)] = bus.wr_data1;
      rd_ptr_d = ptr_add(rd_ptr_q, n_rd);
      wr_ptr_d = ptr_add(wr_ptr_q, n_wr);
      level_d  = level_q + c_lvl_w'(n_wr) - c_lvl_w'(n_rd);
    end

    afull_d = ({1'b0, level_d} >= c_afull);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      afull_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      afull_q  <= afull_d;
    end
  end

  assign bus.rd_valid  = rd_valid;
  assign bus.wr_rdy    = wr_rdy;
  assign bus.rd_data0  = mem_q[rd_ptr_q];
  assign bus.rd_data1  = mem_q[ptr_add(rd_ptr_q, 2'd1)];
  assign level_o       = level_q;
  assign almost_full_o = afull_q;

`ifndef SYNTHESIS
  // Shadow counters: accepted writes minus accepted reads must equal level.
  logic [31:0] tot_wr_q, tot_wr_d;
  logic [31:0] tot_rd_q, tot_rd_d;

  always_comb begin
    tot_wr_d = flush_i ? '0 : tot_wr_q + 32'(n_wr);
    tot_rd_d = flush_i ? '0 : tot_rd_q + 32'(n_rd);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tot_wr_q <= '0;
      tot_rd_q <= '0;
    end else begin
      tot_wr_q <= tot_wr_d;
      tot_rd_q <= tot_rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (level_q <= c_lvl_w'(Depth));
      assert (tot_wr_q - tot_rd_q == 32'(level_q));
      assert (!wr_rdy[1] || wr_rdy[0]);
      assert (!rd_valid[1] || rd_valid[0]);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_stage_fifo_nd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stage_fifo_nd
//  Purpose  : Directed bench for stage_fifo_nd. Three instances share one
//             stimulus stream: Depth=4/PassRead=1, Depth=4/PassRead=0 and
//             Depth=3/PassRead=1. A sequence-numbered reference model is
//             compared on every falling edge; literal checks pin key points.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stage_fifo_nd;

  localparam int DEP [3] = '{4, 4, 3};
  localparam int PR  [3] = '{1, 0, 1};
  localparam int AF  [3] = '{3, 3, 2};

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [1:0]  wv, rr;
  logic [31:0] wd0, wd1;

  stage_fifo_nd_if #(.Width(32)) if0 ();
  stage_fifo_nd_if #(.Width(32)) if1 ();
  stage_fifo_nd_if #(.Width(32)) if2 ();

  logic [2:0] lvl0, lvl1;
  logic [1:0] lvl2;
  logic       af0, af1, af2;

  assign if0.wr_valid = wv;  assign if0.wr_data0 = wd0;
  assign if0.wr_data1 = wd1; assign if0.rd_rdy   = rr;
  assign if1.wr_valid = wv;  assign if1.wr_data0 = wd0;
  assign if1.wr_data1 = wd1; assign if1.rd_rdy   = rr;
  assign if2.wr_valid = wv;  assign if2.wr_data0 = wd0;
  assign if2.wr_data1 = wd1; assign if2.rd_rdy   = rr;

  stage_fifo_nd #(.Width(32), .Depth(4), .PassRead(1)) u_d4p1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(if0.slave),
    .level_o(lvl0), .almost_full_o(af0));
  stage_fifo_nd #(.Width(32), .Depth(4), .PassRead(0)) u_d4p0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(if1.slave),
    .level_o(lvl1), .almost_full_o(af1));
  stage_fifo_nd #(.Width(32), .Depth(3), .PassRead(1)) u_d3p1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(if2.slave),
    .level_o(lvl2), .almost_full_o(af2));

  logic [1:0]  o_rv [3];
  logic [1:0]  o_wr [3];
  logic [31:0] o_d0 [3];
  logic [31:0] o_d1 [3];
  logic [31:0] o_lv [3];
  logic        o_af [3];

  assign o_rv[0] = if0.rd_valid; assign o_rv[1] = if1.rd_valid; assign o_rv[2] = if2.rd_valid;
  assign o_wr[0] = if0.wr_rdy;   assign o_wr[1] = if1.wr_rdy;   assign o_wr[2] = if2.wr_rdy;
  assign o_d0[0] = if0.rd_data0; assign o_d0[1] = if1.rd_data0; assign o_d0[2] = if2.rd_data0;
  assign o_d1[0] = if0.rd_data1; assign o_d1[1] = if1.rd_data1; assign o_d1[2] = if2.rd_data1;
  assign o_lv[0] = 32'(lvl0);    assign o_lv[1] = 32'(lvl1);    assign o_lv[2] = 32'(lvl2);
  assign o_af[0] = af0;          assign o_af[1] = af1;          assign o_af[2] = af2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
    end
  endtask

  // Reference model: every accepted write gets the next sequence number; the
  // FIFO contents are the entries between the read and write sequence numbers.
  logic [31:0] mdata [3][1024];
  int          wseq [3] = '{0, 0, 0};
  int          rseq [3] = '{0, 0, 0};

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      int lvl, avail, want_rd, want_wr, nrd, nwr, room;
      logic [1:0] erv, ewr;
      if (!rst_n) begin
        wseq[d] = 0;
        rseq[d] = 0;
      end
      lvl     = wseq[d] - rseq[d];
      avail   = (lvl < 2) ? lvl : 2;
      want_rd = (rr == 2'b11) ? 2 : (rr == 2'b01) ? 1 : 0;
      want_wr = (wv == 2'b11) ? 2 : (wv == 2'b01) ? 1 : 0;
      nrd     = (want_rd < avail) ? want_rd : avail;
      room    = DEP[d] - lvl + ((PR[d] != 0) ? nrd : 0);
      room    = (room < 2) ? room : 2;
      nwr     = (want_wr < room) ? want_wr : room;
      erv     = (avail == 2) ? 2'b11 : (avail == 1) ? 2'b01 : 2'b00;
      ewr     = (room == 2) ? 2'b11 : (room == 1) ? 2'b01 : 2'b00;

      chk("level", d, o_lv[d], 32'(lvl));
      chk("almost_full", d, 32'(o_af[d]), 32'(lvl >= AF[d]));
      chk("rd_valid", d, 32'(o_rv[d]), 32'(erv));
      chk("wr_rdy", d, 32'(o_wr[d]), 32'(ewr));
      if (!rst_n) begin
        chk("rd_data0_rst", d, o_d0[d], 32'h0);
        chk("rd_data1_rst", d, o_d1[d], 32'h0);
      end else begin
        if (lvl >= 1) chk("rd_data0", d, o_d0[d], mdata[d][rseq[d]]);
        if (lvl >= 2) chk("rd_data1", d, o_d1[d], mdata[d][rseq[d] + 1]);
        if (flush) begin
          rseq[d] = wseq[d];
        end else begin
          if (nwr >= 1) mdata[d][wseq[d]]     = wd0;
          if (nwr == 2) mdata[d][wseq[d] + 1] = wd1;
          wseq[d] = wseq[d] + nwr;
          rseq[d] = rseq[d] + nrd;
        end
      end
    end
  end

  task automatic drive(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] r, input logic f);
    wv = v; wd0 = a; wd1 = b; rr = r; flush = f;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(2'b00, 0, 0, 2'b00, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    chk("lit_rst_level", 0, o_lv[0], 32'd0);
    chk("lit_rst_rv", 0, 32'(o_rv[0]), 32'd0);
    chk("lit_rst_wr", 0, 32'(o_wr[0]), 32'd3);
    chk("lit_rst_af", 0, 32'(o_af[0]), 32'd0);
    chk("lit_rst_d0", 0, o_d0[0], 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    tick();

    // Fill: A,B then C,D with no reads.
    drive(2'b11, 32'hA, 32'hB, 2'b00, 1'b0); tick();
    drive(2'b11, 32'hC, 32'hD, 2'b00, 1'b0);
    chk("lit_lvl2", 0, o_lv[0], 32'd2);
    chk("lit_af_lvl2", 0, 32'(o_af[0]), 32'd0);
    chk("lit_af_d3_lvl2", 2, 32'(o_af[2]), 32'd1);
    chk("lit_wr_one_room", 2, 32'(o_wr[2]), 32'd1);
    tick();
    drive(2'b00, 0, 0, 2'b00, 1'b0);
    chk("lit_full_lvl", 0, o_lv[0], 32'd4);
    chk("lit_full_wr", 0, 32'(o_wr[0]), 32'd0);
    chk("lit_full_af", 0, 32'(o_af[0]), 32'd1);
    chk("lit_d3_lvl", 2, o_lv[2], 32'd3);

    // Read two and write two at full.
    drive(2'b11, 32'hE, 32'hF, 2'b11, 1'b0);
    chk("lit_pass_d0", 0, o_d0[0], 32'hA);
    chk("lit_pass_d1", 0, o_d1[0], 32'hB);
    chk("lit_pass_wr", 0, 32'(o_wr[0]), 32'd3);
    chk("lit_nopass_wr", 1, 32'(o_wr[1]), 32'd0);
    tick();
    drive(2'b00, 0, 0, 2'b00, 1'b0);
    chk("lit_pass_lvl", 0, o_lv[0], 32'd4);
    chk("lit_nopass_lvl", 1, o_lv[1], 32'd2);
    chk("lit_after_d0", 0, o_d0[0], 32'hC);
    chk("lit_after_d1", 0, o_d1[0], 32'hD);
    drive(2'b00, 0, 0, 2'b11, 1'b0); tick();
    drive(2'b00, 0, 0, 2'b11, 1'b0);
    chk("lit_tail_d0", 0, o_d0[0], 32'hE);
    chk("lit_tail_d1", 0, o_d1[0], 32'hF);
    chk("lit_single_rv", 2, 32'(o_rv[2]), 32'd1);
    chk("lit_single_d0", 2, o_d0[2], 32'hF);
    tick();
    drive(2'b00, 0, 0, 2'b00, 1'b0);
    chk("lit_empty0", 0, o_lv[0], 32'd0);
    chk("lit_empty2", 2, o_lv[2], 32'd0);

    // Pointer wrap on the depth-3 instance: push 1,2,3; pop 2; push 4,5; pop 3.
    drive(2'b11, 32'd1, 32'd2, 2'b00, 1'b0); tick();
    drive(2'b01, 32'd3, 32'd0, 2'b00, 1'b0); tick();
    drive(2'b00, 0, 0, 2'b11, 1'b0);
    chk("lit_wrap_d0a", 2, o_d0[2], 32'd1);
    chk("lit_wrap_d1a", 2, o_d1[2], 32'd2);
    tick();
    drive(2'b11, 32'd4, 32'd5, 2'b00, 1'b0); tick();
    drive(2'b00, 0, 0, 2'b11, 1'b0);
    chk("lit_wrap_lvl", 2, o_lv[2], 32'd3);
    chk("lit_wrap_d0b", 2, o_d0[2], 32'd3);
    chk("lit_wrap_d1b", 2, o_d1[2], 32'd4);
    tick();
    drive(2'b00, 0, 0, 2'b01, 1'b0);
    chk("lit_wrap_d0c", 2, o_d0[2], 32'd5);
    tick();

    // Illegal request codes are no-ops.
    drive(2'b10, 32'h99, 32'h98, 2'b00, 1'b0); tick();
    drive(2'b00, 0, 0, 2'b00, 1'b0);
    chk("lit_wv10_lvl", 0, o_lv[0], 32'd0);
    drive(2'b11, 32'h7, 32'h8, 2'b00, 1'b0); tick();
    drive(2'b00, 0, 0, 2'b10, 1'b0); tick();
    drive(2'b00, 0, 0, 2'b00, 1'b0);
    chk("lit_rr10_lvl", 0, o_lv[0], 32'd2);
    drive(2'b00, 0, 0, 2'b11, 1'b0); tick();

    // Flush beats a coincident write and read at level 3.
    drive(2'b11, 32'h11, 32'h12, 2'b00, 1'b0); tick();
    drive(2'b01, 32'h13, 32'h0, 2'b00, 1'b0); tick();
    drive(2'b11, 32'h14, 32'h15, 2'b11, 1'b1);
    chk("lit_preflush_lvl", 0, o_lv[0], 32'd3);
    tick();
    drive(2'b00, 0, 0, 2'b00, 1'b0);
    chk("lit_flush_lvl", 0, o_lv[0], 32'd0);
    chk("lit_flush_rv", 0, 32'(o_rv[0]), 32'd0);
    chk("lit_flush_wr", 0, 32'(o_wr[0]), 32'd3);
    chk("lit_flush_lvl_d3", 2, o_lv[2], 32'd0);

    // Asynchronous reset in mid-stream.
    drive(2'b11, 32'h6, 32'h7, 2'b00, 1'b0); tick();
    drive(2'b00, 0, 0, 2'b00, 1'b0);
    chk("lit_prerst_lvl", 0, o_lv[0], 32'd2);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("lit_arst_lvl", 0, o_lv[0], 32'd0);
    chk("lit_arst_rv", 0, 32'(o_rv[0]), 32'd0);
    chk("lit_arst_wr", 0, 32'(o_wr[0]), 32'd3);
    chk("lit_arst_d0", 0, o_d0[0], 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    tick();
    drive(2'b01, 32'h55, 32'h0, 2'b00, 1'b0); tick();
    drive(2'b00, 0, 0, 2'b01, 1'b0);
    chk("lit_post_d0", 0, o_d0[0], 32'h55);
    tick();
    drive(2'b00, 0, 0, 2'b00, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stage_fifo_nd.md
Name: stage_fifo_nd

Overview:
Parametrised successor to the 2-deep dual-issue pipeline FIFO, used between pipeline stages that need deeper decoupling.
- Depth is configurable. Two writes and two reads are possible per cycle using valid/rdy handshakes on both sides.
- Adds an occupancy output, an almost-full flag and a selectable write-ready mode for timing trade-offs.
- Sits between the fetch/decode and decode/issue stages; it is flushed on pipeline redirect.

Parameters:
Width, 32, data width of each entry
Depth, 4, number of entries; legal values are 2..64 (any integer, not restricted to powers of two)
AFullLevel, Depth-1, almost_full_o asserts when level >= AFullLevel; legal values are 1..Depth
PassRead, 1, 1: wr_rdy_o counts same-cycle reads as free room; 0: wr_rdy_o depends on registered level only (no rd_rdy_i->wr_rdy_o path)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  synchronous flush; empties the FIFO
wr_valid_i  in  2  write request: 00 none, 01 one, 11 two
wr_data0_i  in  Width  first sequential write data
wr_data1_i  in  Width  second sequential write data
wr_rdy_o  out  2  write room: 00, 01 or 11
rd_rdy_i  in  2  read request: 00, 01 or 11
rd_valid_o  out  2  read data available: 00, 01 or 11
rd_data0_o  out  Width  oldest entry
rd_data1_o  out  Width  second-oldest entry
level_o  out  $clog2(Depth+1)  current occupancy (registered)
almost_full_o  out  1  level_o >= AFullLevel (registered)

Behaviour:
- Clock clk_i; reset rst_ni, asynchronous, active-low.
- Reset state:
  - Read pointer, write pointer and level cleared to 0; all storage entries cleared to 0.
  - Outputs: rd_valid_o=00, wr_rdy_o=11, level_o=0, almost_full_o=0 (for any AFullLevel>=1), rd_data0_o=rd_data1_o=0.
- Input encoding:
  - Handshake input value 10 is illegal and is treated as 00 (no operation).
  - The block drives only 00, 01 or 11 on rd_valid_o and wr_rdy_o.
- Read side:
  - rd_valid_o[0] = (level>=1); rd_valid_o[1] = (level>=2).
  - rd_data0_o = mem[rd_ptr]; rd_data1_o = mem[(rd_ptr+1) mod Depth].
  - Data on an invalid lane is unspecified and must not be checked.
- Reads accepted per cycle: n_rd = popcount(rd_rdy_i & rd_valid_o). Example: rd_rdy_i=11 with rd_valid_o=01 gives exactly one read.
- Write room:
  - free = Depth - level + (PassRead ? n_rd : 0).
  - wr_rdy_o[0] = (free>=1); wr_rdy_o[1] = (free>=2).
- Writes accepted per cycle: n_wr = popcount(wr_valid_i & wr_rdy_o).
  - If wr_valid_i=11 and wr_rdy_o=01, only wr_data0_i is written.
  - wr_data0_i goes to mem[wr_ptr]; wr_data1_i goes to mem[(wr_ptr+1) mod Depth].
- Register update per cycle:
  - level <= level + n_wr - n_rd.
  - rd_ptr <= (rd_ptr+n_rd) mod Depth; wr_ptr <= (wr_ptr+n_wr) mod Depth.
  - Pointer wrap is explicit modulo Depth (compare and subtract) so that non-power-of-two depths work.
- Latency: no fall-through. Data written in cycle N is first visible on the read side in cycle N+1. A write to an empty FIFO is never readable in the same cycle.
- Simultaneous read and write at full:
  - PassRead=1: entries freed by reads are reusable in the same cycle. The write lands in the slot that is being read, and the read returns the old contents.
  - PassRead=0: the write is refused at full.
- Flush:
  - flush_i has priority over all reads and writes in the same cycle.
  - Next cycle: level=0, both pointers=0, rd_valid_o=00, wr_rdy_o=11.
  - Storage is not cleared on flush.
  - Handshakes that coincide with flush are discarded. The upstream side must treat them as not accepted, even though wr_rdy_o was high.
- Reset mid-operation: immediately returns the block to the reset state, regardless of clock.
- Invariants:
  - level never exceeds Depth and never goes below 0.
  - wr_rdy_o[1] implies wr_rdy_o[0]; rd_valid_o[1] implies rd_valid_o[0].
  - With PassRead=0, wr_rdy_o is a function of registers only.
- Simulation-only checks:
  - Shadow-counter assertions verifying level_o against the tracked occupancy.
  - Total written minus total read equals level_o (counters reset on flush).

Test Plan:
- Depth=4, PassRead=1. Write 11 (A,B) then 11 (C,D) with rd_rdy_i=00 -> level 2 then 4; wr_rdy_o=00; almost_full_o=1 from level 3 onwards.
- From full (A,B,C,D), rd_rdy_i=11 and wr_valid_i=11 (E,F) in the same cycle, PassRead=1 -> rd_data0/1=A,B; both writes accepted; level stays 4; subsequent reads return C,D,E,F.
- Same stimulus as the previous scenario with PassRead=0 -> wr_rdy_o=00 and no writes accepted; level becomes 2.
- Depth=3: push 1,2,3; pop 2; push 4,5; pop 3 -> read order 1,2,3,4,5; pointer wrap is correct at index 2->0.
- Level 1 (X): rd_rdy_i=11 -> rd_valid_o=01, only X consumed, level 0; wr_valid_i=10 -> nothing written.
- Level 3 with wr_valid_i=11 and flush_i=1 -> next cycle level_o=0, rd_valid_o=00, wr_rdy_o=11; assert rst_ni low mid-stream -> outputs return to reset values asynchronously.
